// File: rtl/sar_adc_pkg.sv
// Shared types and default constants for the SAR ADC controller slice.
// The optional SAR_ADC_OVR_FLAG_EN macro is handled in the interface and top files.
package sar_adc_pkg;

    localparam int SAR_WIDTH_DEF  = 8;
    localparam int SAR_SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_e;

endpackage

// File: rtl/sar_adc_if.sv
// Handshake/analog-front-end bundle between a SAR controller and its environment.
// With SAR_ADC_OVR_FLAG_EN defined the bundle also carries the sticky overrun_o flag.
interface sar_adc_if
    import sar_adc_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
);
    logic             start_i;
    logic             cmp_i;
    logic             ready_i;
    logic             sample_o;
    logic [WIDTH-1:0] dac_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
`ifdef SAR_ADC_OVR_FLAG_EN
    logic             overrun_o;

    modport master (output start_i, cmp_i, ready_i,
                    input  sample_o, dac_o, busy_o, valid_o, data_o, overrun_o);
    modport slave  (input  start_i, cmp_i, ready_i,
                    output sample_o, dac_o, busy_o, valid_o, data_o, overrun_o);
`else
    modport master (output start_i, cmp_i, ready_i,
                    input  sample_o, dac_o, busy_o, valid_o, data_o);
    modport slave  (input  start_i, cmp_i, ready_i,
                    output sample_o, dac_o, busy_o, valid_o, data_o);
`endif
endinterface

// File: rtl/sar_settle_cnt.sv
// Per-phase settle timer: reload on phase entry, count down, flag the phase's last cycle.
module sar_settle_cnt
    import sar_adc_pkg::*;
#(
    parameter int SETTLE_CYCLES = SAR_SETTLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [3:0] cnt_r;

    // Down-counter; holds at zero until the next phase reloads it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == 4'd0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample, MSB-first binary search, hold result.
// Defining SAR_ADC_OVR_FLAG_EN adds a sticky overrun_o for starts while busy or holding a result.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = SAR_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SAR_SETTLE_DEF
) (
    input logic      clk,
    input logic      rst,
    sar_adc_if.slave bus
);
    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = ONE << (WIDTH - 1);

    sar_state_e       state_r, state_nx_s;
    logic [IDX_W-1:0] bit_idx_r;
    logic [WIDTH-1:0] dac_r, data_r, mask_s, kept_s;
    logic             sample_r, busy_r, valid_r;
    logic             sample_nx_s, busy_nx_s, valid_nx_s;
    logic             settle_done_s, settle_load_s, last_bit_s, accept_s;

    assign mask_s        = ONE << bit_idx_r;
    assign kept_s        = bus.cmp_i ? dac_r : (dac_r & ~mask_s);
    assign last_bit_s    = (bit_idx_r == IDX_W'(0));
    assign accept_s      = valid_r && bus.ready_i;
    assign settle_load_s = (state_r == ST_IDLE) || settle_done_s;

    sar_settle_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load_s),
        .done (settle_done_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) state_nx_s = ST_SAMPLE;
                else             state_nx_s = ST_IDLE;
            end
            ST_SAMPLE: begin
                if (settle_done_s) state_nx_s = ST_CONVERT;
                else               state_nx_s = ST_SAMPLE;
            end
            ST_CONVERT: begin
                if (settle_done_s && last_bit_s) state_nx_s = ST_DONE;
                else                             state_nx_s = ST_CONVERT;
            end
            ST_DONE: begin
                if (accept_s) state_nx_s = ST_IDLE;
                else          state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the status outputs come straight from flops
    always_comb begin
        sample_nx_s = 1'b0;
        busy_nx_s   = 1'b0;
        valid_nx_s  = 1'b0;
        case (state_nx_s)
            ST_SAMPLE:  begin sample_nx_s = 1'b1; busy_nx_s = 1'b1; end
            ST_CONVERT: busy_nx_s  = 1'b1;
            ST_DONE:    valid_nx_s = 1'b1;
            default:    valid_nx_s = 1'b0;
        endcase
    end

    // Status output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_r <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            sample_r <= sample_nx_s;
            busy_r   <= busy_nx_s;
            valid_r  <= valid_nx_s;
        end
    end

    // Binary-search datapath: dac_r always shows kept bits plus the bit under trial
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_r     <= WIDTH'(0);
            data_r    <= WIDTH'(0);
            bit_idx_r <= IDX_W'(0);
        end else begin
            case (state_r)
                ST_SAMPLE: begin
                    if (settle_done_s) begin
                        dac_r     <= MSB_MASK;
                        bit_idx_r <= IDX_W'(WIDTH - 1);
                    end
                end
                ST_CONVERT: begin
                    if (settle_done_s) begin
                        if (last_bit_s) begin
                            dac_r  <= kept_s;
                            data_r <= kept_s;
                        end else begin
                            dac_r     <= kept_s | (mask_s >> 1);
                            bit_idx_r <= bit_idx_r - IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (accept_s) dac_r <= WIDTH'(0);
                end
                default: dac_r <= WIDTH'(0);
            endcase
        end
    end

    assign bus.sample_o = sample_r;
    assign bus.busy_o   = busy_r;
    assign bus.valid_o  = valid_r;
    assign bus.dac_o    = dac_r;
    assign bus.data_o   = data_r;

`ifdef SAR_ADC_OVR_FLAG_EN
    logic overrun_r;

    // Sticky overrun: a start request arrived while a conversion or result was outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (bus.start_i && (busy_r || valid_r)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.overrun_o = overrun_r;
`endif

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: conversion resolution in bits (legal 2..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: clocks per sample/trial phase to let the RC load settle (legal 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start_i, input, 1: conversion request, sampled only in IDLE.
REQ-006 SHALL have port cmp_i, input, 1: comparator result, synchronous to clk; 1 = analog input >= DAC level.
REQ-007 SHALL have port sample_o, output, 1: track/hold switch control driving the RC sampling node.
REQ-008 SHALL have port dac_o, output, WIDTH: trial code to the reference DAC.
REQ-009 SHALL have port busy_o, output, 1: high in SAMPLE and CONVERT.
REQ-010 SHALL have port valid_o, output, 1: result valid.
REQ-011 SHALL have port ready_i, input, 1: downstream accepts result.
REQ-012 SHALL have port data_o, output, WIDTH: conversion result.

Function
REQ-013 SHALL implement FSM IDLE -> SAMPLE -> CONVERT -> DONE -> IDLE.
REQ-014 IDLE: start_i=1 SHALL move to SAMPLE next cycle; otherwise stay.
REQ-015 SAMPLE: sample_o=1, dac_o=0 for exactly SETTLE_CYCLES cycles, then CONVERT.
REQ-016 CONVERT: WIDTH trials MSB first, each SETTLE_CYCLES cycles; dac_o = kept bits | trial bit.
REQ-017 cmp_i SHALL be sampled only on the last cycle of each trial; 1 keeps the trial bit, 0 clears it.
REQ-018 After the LSB trial, FSM SHALL enter DONE with valid_o=1, data_o=final code, dac_o=final code.
REQ-019 Latency start_i accepted -> valid_o high SHALL be SETTLE_CYCLES*(WIDTH+1)+1 cycles (19 at defaults).
REQ-020 DONE: valid_o and data_o SHALL hold stable until ready_i=1; the valid&&ready cycle returns to IDLE.
REQ-021 start_i outside IDLE SHALL be ignored (no restart, no queuing), including the valid&&ready cycle.
REQ-022 In IDLE, sample_o=0, dac_o=0, valid_o=0; data_o SHALL retain the last result.
REQ-023 Settle counter and bit index SHALL reload on every phase entry; no wrap past bit 0.

Reset
REQ-024 rst=1 SHALL force IDLE immediately, any phase included, aborting any conversion.
REQ-025 Reset values: sample_o=0, dac_o=0, busy_o=0, valid_o=0, data_o=0, overrun_o=0 (if present).

Configuration
REQ-026 With SAR_ADC_OVR_FLAG_EN defined, SHALL add output overrun_o (1 bit), set sticky when start_i=1 while busy_o=1 or valid_o=1, cleared only by rst.
REQ-027 Without SAR_ADC_OVR_FLAG_EN, overrun_o and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package sar_adc_pkg SHALL hold the FSM state enum and the WIDTH/SETTLE_CYCLES default constants.
REQ-029 The settle counter SHALL be a sub-module sar_settle_cnt (load, count-down, done pulse).

Verification
REQ-030 Defaults, cmp_i = (dac_o <= 0xA5), start at cycle 0 -> valid_o at cycle 19, data_o=0xA5.
REQ-031 cmp_i always 1 -> 0xFF; always 0 -> 0x00; dac_o trial sequence 0x80,0x40,...,0x01 in all-0 case.
REQ-032 ready_i held 0 for 10 cycles after valid -> valid_o/data_o stable; ready_i=1 -> IDLE next cycle.
REQ-033 rst pulsed at cycle 8 of a conversion -> all outputs 0 asynchronously; fresh start converts correctly.
REQ-034 start_i held high continuously with ready_i=1 -> back-to-back conversions every 20 cycles, no extra starts.
REQ-035 SAR_ADC_OVR_FLAG_EN defined, start_i pulse at cycle 5 of conversion -> overrun_o=1 and stays until rst.
